// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK bank sequencer: opcodes, FSM states, default widths.
package jk_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to 0.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer clocking a bank of jk_cell instances as a loadable up/down counter.
// Optional JK_SEQ_ABORT_EN adds an abort input that ends EXEC early without a final q update.
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done,
    output logic             wrap
`ifdef JK_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_next;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] j, k;
    logic             accept, abort_hit, step_en, wrap_next;

`ifdef JK_SEQ_ABORT_EN
    assign abort_hit = (state == EXEC) && abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign accept  = (state == IDLE) && cmd_valid;
    assign step_en = (state == EXEC) && !abort_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_valid) state_next = (cmd_count == '0) ? DONE : EXEC;
            EXEC: if (abort_hit || remaining == ONE) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rst gates cmd_ready directly so it reads low throughout the reset cycle.
    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    // NOTE: command registers are only meaningful after an accept, but resetting
    // them keeps simulation free of X on op_r-driven excitation after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= OP_HOLD;
            data_r    <= '0;
            remaining <= '0;
        end else if (accept) begin
            op_r      <= cmd_op;
            data_r    <= cmd_data;
            remaining <= cmd_count;
        end else if (state == EXEC) begin
            remaining <= remaining - ONE;
        end
    end

    // NOTE: the carry chain uses a blocking running variable inside always_comb;
    // sequential state elsewhere uses non-blocking assignments only.
    always_comb begin
        logic run;
        j   = '0;
        k   = '0;
        run = 1'b1;
        if (step_en) begin
            case (op_r)
                OP_CLEAR:  k = '1;
                OP_SET:    j = '1;
                OP_LOAD:   begin j = data_r; k = ~data_r; end
                OP_TOGGLE: begin j = '1; k = '1; end
                OP_UP: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j[i] = run;
                        k[i] = run;
                        run  = run & q[i];
                    end
                end
                OP_DOWN: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j[i] = run;
                        k[i] = run;
                        run  = run & ~q[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign wrap_next = step_en && (((op_r == OP_UP) && (&q)) || ((op_r == OP_DOWN) && (~|q)));

    always_ff @(posedge clk) begin
        if (rst) wrap <= 1'b0;
        else     wrap <= wrap_next;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[g]),
            .k   (k[g]),
            .q   (q[g]),
            .qb  (qb[g])
        );
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed self-checking bench for jk_bank_sequencer (WIDTH=4); abort test built with JK_SEQ_ABORT_EN.
module tb_jk_bank_sequencer;
    import jk_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_count;
    logic [3:0] q, qb;
    logic       busy, done, wrap;
`ifdef JK_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .q         (q),
        .qb        (qb),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
`ifdef JK_SEQ_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations captured by run_cmd, indexed by edge after accept (0 = edge T0+1).
    logic [3:0] obs_q [0:31];
    logic       obs_wrap [0:31];
    int         obs_done_at, obs_done_cnt, obs_wrap_cnt, obs_ready_at;
    logic [3:0] obs_final_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one command and records q/wrap/done/ready around it. While busy the command
    // inputs are scrambled and cmd_valid stays high, which must have no effect.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input int n);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = 8'(n);
        while (!cmd_ready && waited < 40) begin
            tick;
            waited++;
        end
        if (!cmd_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ready_timeout: cmd_ready got %b required 1", cmd_ready);
        end
        tick;
        cmd_op    = ~op;
        cmd_data  = ~data;
        cmd_count = 8'(n + 7);
        obs_done_at  = -1;
        obs_done_cnt = 0;
        obs_wrap_cnt = 0;
        obs_ready_at = -1;
        for (int jj = 0; jj <= n + 3; jj++) begin
            if (jj > 0) tick;
            if (jj >= 1 && jj <= n) begin
                obs_q[jj-1]    = q;
                obs_wrap[jj-1] = wrap;
            end
            if (wrap) obs_wrap_cnt++;
            if (done) begin
                obs_done_cnt++;
                if (obs_done_at < 0) obs_done_at = jj;
            end
            if (cmd_ready && obs_ready_at < 0) obs_ready_at = jj;
            if (jj == n) cmd_valid = 1'b0;
        end
        obs_final_q = q;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        tests_run++; if (q !== 4'b0000) begin tests_failed++; $display("FAIL reset_q got %b required 0000", q); end
        tests_run++; if (qb !== 4'b1111) begin tests_failed++; $display("FAIL reset_qb got %b required 1111", qb); end
        tests_run++; if ({busy, done, wrap} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags busy/done/wrap got %b required 000", {busy, done, wrap}); end
        tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_in_reset got %b required 0", cmd_ready); end
        rst = 1'b0;
        #1;
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after got %b required 1", cmd_ready); end
        tick;
    endtask

    task automatic test_load;
        run_cmd(OP_LOAD, 4'b1010, 1);
        tests_run++; if (obs_q[0] !== 4'b1010) begin tests_failed++; $display("FAIL load_q got %b required 1010", obs_q[0]); end
        tests_run++; if (obs_done_at != 1 || obs_done_cnt != 1) begin tests_failed++; $display("FAIL load_done at %0d count %0d required at 1 count 1", obs_done_at, obs_done_cnt); end
        tests_run++; if (obs_wrap_cnt != 0) begin tests_failed++; $display("FAIL load_wrap got %0d pulses required 0", obs_wrap_cnt); end
        tests_run++; if (qb !== 4'b0101) begin tests_failed++; $display("FAIL load_qb got %b required 0101", qb); end
    endtask

    task automatic test_up_wrap;
        logic [3:0] exp_q [0:4] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
        run_cmd(OP_LOAD, 4'b1101, 1);
        run_cmd(OP_UP, 4'b0000, 5);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL up_seq[%0d] got %b required %b", i, obs_q[i], exp_q[i]); end
        end
        tests_run++; if (obs_wrap_cnt != 1 || obs_wrap[2] !== 1'b1) begin tests_failed++; $display("FAIL up_wrap got %0d pulses, after edge3 %b; required 1 pulse after edge3", obs_wrap_cnt, obs_wrap[2]); end
        tests_run++; if (obs_done_at != 5) begin tests_failed++; $display("FAIL up_done_at got %0d required 5", obs_done_at); end
    endtask

    task automatic test_down_wrap;
        logic [3:0] exp_q [0:2] = '{4'b0000, 4'b1111, 4'b1110};
        run_cmd(OP_LOAD, 4'b0001, 1);
        run_cmd(OP_DOWN, 4'b0000, 3);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL down_seq[%0d] got %b required %b", i, obs_q[i], exp_q[i]); end
        end
        tests_run++; if (obs_wrap_cnt != 1 || obs_wrap[1] !== 1'b1) begin tests_failed++; $display("FAIL down_wrap got %0d pulses, after edge2 %b; required 1 pulse after edge2", obs_wrap_cnt, obs_wrap[1]); end
    endtask

    // Accept spacing = cycles from accept edge to the next possible accept edge (N+2).
    task automatic test_set_toggle_clear;
        run_cmd(OP_SET, 4'b0000, 1);
        tests_run++; if (obs_q[0] !== 4'b1111) begin tests_failed++; $display("FAIL set_q got %b required 1111", obs_q[0]); end
        tests_run++; if (obs_ready_at + 1 != 3) begin tests_failed++; $display("FAIL set_spacing got %0d required 3", obs_ready_at + 1); end
        run_cmd(OP_TOGGLE, 4'b0000, 2);
        tests_run++; if (obs_q[0] !== 4'b0000 || obs_q[1] !== 4'b1111) begin tests_failed++; $display("FAIL toggle_seq got %b,%b required 0000,1111", obs_q[0], obs_q[1]); end
        tests_run++; if (obs_ready_at + 1 != 4) begin tests_failed++; $display("FAIL toggle_spacing got %0d required 4", obs_ready_at + 1); end
        run_cmd(OP_CLEAR, 4'b1111, 1);
        tests_run++; if (obs_q[0] !== 4'b0000) begin tests_failed++; $display("FAIL clear_q got %b required 0000", obs_q[0]); end
        tests_run++; if (obs_ready_at + 1 != 3) begin tests_failed++; $display("FAIL clear_spacing got %0d required 3", obs_ready_at + 1); end
    endtask

    task automatic test_count_zero;
        run_cmd(OP_LOAD, 4'b0110, 1);
        run_cmd(OP_TOGGLE, 4'b0000, 0);
        tests_run++; if (obs_final_q !== 4'b0110) begin tests_failed++; $display("FAIL zero_q got %b required 0110", obs_final_q); end
        tests_run++; if (obs_done_at != 0 || obs_done_cnt != 1) begin tests_failed++; $display("FAIL zero_done at %0d count %0d required at 0 count 1", obs_done_at, obs_done_cnt); end
        tests_run++; if (obs_ready_at != 1) begin tests_failed++; $display("FAIL zero_ready_at got %0d required 1", obs_ready_at); end
    endtask

    task automatic test_reserved;
        run_cmd(OP_LOAD, 4'b1001, 1);
        run_cmd(3'b111, 4'b0110, 2);
        tests_run++; if (obs_q[0] !== 4'b1001 || obs_q[1] !== 4'b1001) begin tests_failed++; $display("FAIL reserved_q got %b,%b required 1001,1001", obs_q[0], obs_q[1]); end
        tests_run++; if (obs_done_at != 2 || obs_done_cnt != 1) begin tests_failed++; $display("FAIL reserved_done at %0d count %0d required at 2 count 1", obs_done_at, obs_done_cnt); end
    endtask

    task automatic test_multi_wrap;
        run_cmd(OP_LOAD, 4'b1110, 1);
        run_cmd(OP_UP, 4'b0000, 18);
        tests_run++; if (obs_wrap_cnt != 2 || obs_wrap[1] !== 1'b1 || obs_wrap[17] !== 1'b1) begin tests_failed++; $display("FAIL multi_wrap got %0d pulses (edge2 %b edge18 %b) required 2 at edges 2,18", obs_wrap_cnt, obs_wrap[1], obs_wrap[17]); end
        tests_run++; if (obs_final_q !== 4'b0000) begin tests_failed++; $display("FAIL multi_wrap_q got %b required 0000", obs_final_q); end
    endtask

    task automatic test_reset_mid;
        int done_seen = 0;
        int busy_seen = 0;
        run_cmd(OP_LOAD, 4'b0101, 1);
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_count = 8'd10;
        tick;
        cmd_valid = 1'b0;
        tick; tick; tick;
        tests_run++; if (q !== 4'b1000) begin tests_failed++; $display("FAIL midreset_pre_q got %b required 1000", q); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests_run++; if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL midreset_state q %b busy %b done %b required 0000 0 0", q, busy, done); end
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        tests_run++; if (done_seen != 0 || busy_seen != 0) begin tests_failed++; $display("FAIL midreset_quiet done %0d busy %0d cycles required 0 0", done_seen, busy_seen); end
        // A command presented together with rst must be dropped.
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_count = 8'd1; rst = 1'b1;
        tick;
        cmd_valid = 1'b0; rst = 1'b0;
        tick; tick;
        tests_run++; if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL rst_drop q %b busy %b done %b required 0000 0 0", q, busy, done); end
    endtask

`ifdef JK_SEQ_ABORT_EN
    task automatic test_abort;
        run_cmd(OP_CLEAR, 4'b0000, 1);
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_count = 8'd8;
        tick;
        cmd_valid = 1'b0;
        tick; tick; tick;
        tests_run++; if (q !== 4'b0011) begin tests_failed++; $display("FAIL abort_pre_q got %b required 0011", q); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tests_run++; if (q !== 4'b0011 || done !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL abort_done q %b done %b busy %b required 0011 1 1", q, done, busy); end
        tick;
        tests_run++; if (q !== 4'b0011 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL abort_idle q %b busy %b done %b required 0011 0 0", q, busy, done); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_HOLD;
        cmd_data  = 4'b0000;
        cmd_count = 8'd0;
        test_reset;
        test_load;
        test_up_wrap;
        test_down_wrap;
        test_set_toggle_clear;
        test_count_zero;
        test_reserved;
        test_multi_wrap;
        test_reset_mid;
`ifdef JK_SEQ_ABORT_EN
        test_abort;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
